// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared UART constants and elaboration-time helpers. It holds
//                the legality limits for the oversampling ratio and the
//                accumulator width. It also holds the function that derives
//                the default phase increment from clock and baud rate.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Legal oversampling ratios are even and at least this value.
    localparam int c_OS_MIN    = 4;
    // Accumulator width limits that keep the increment arithmetic in 64 bits.
    localparam int c_ACC_W_MIN = 2;
    localparam int c_ACC_W_MAX = 32;

    // True when the oversampling ratio and accumulator width are usable.
    function automatic bit params_legal(input int os, input int acc_w);
        return (os >= c_OS_MIN) && ((os % 2) == 0) &&
               (acc_w >= c_ACC_W_MIN) && (acc_w <= c_ACC_W_MAX);
    endfunction

    // Compute round(baud*os*2^acc_w / clk_freq), clamped to 2^(acc_w-1).
    // The clamp ensures that at most one sample tick occurs every two clocks.
    function automatic longint unsigned calc_inc0(input int clk_freq,
                                                  input int baud,
                                                  input int os,
                                                  input int acc_w);
        longint unsigned l_clk;
        longint unsigned l_num;
        longint unsigned l_quo;
        longint unsigned l_lim;
        l_clk = 64'(clk_freq);
        l_num = (64'(baud) * 64'(os)) << acc_w;
        l_quo = (l_num + (l_clk >> 1)) / l_clk;
        l_lim = 64'd1 << (acc_w - 1);
        return (l_quo > l_lim) ? l_lim : l_quo;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/brg_phase_acc.sv
`default_nettype none
// ============================================================================
//  Module      : brg_phase_acc
//  Description : Phase accumulator for the baud generator. This block holds
//                the accumulator, the active increment and the registered
//                carry. The registered carry is the sample tick. The block
//                also exposes a combinational overflow flag, which the parent
//                uses to advance its sub-bit counter on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module brg_phase_acc #(
    parameter int               ACC_W = 24,
    parameter logic [ACC_W-1:0] INC0  = '0
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_resync,
    input  logic             i_incr_load,
    input  logic [ACC_W-1:0] i_incr_in,
    output logic             o_ovf,
    output logic             o_carry,
    output logic [ACC_W-1:0] o_inc
);

    localparam logic [ACC_W-1:0] c_INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic             r_carry;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_inc_clamped;

    // Form the ACC_W+1 bit sum and clamp any incoming increment to half scale.
    always_comb begin
        w_sum         = {1'b0, r_acc} + {1'b0, r_inc};
        w_inc_clamped = (i_incr_in > c_INC_MAX) ? c_INC_MAX : i_incr_in;
    end

    // An overflow counts only on an edge that actually accumulates.
    assign o_ovf   = i_en & ~i_resync & w_sum[ACC_W];
    assign o_carry = r_carry;
    assign o_inc   = r_inc;

    // Accumulate, reload the increment, and restart phase on resync.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_inc   <= INC0;
            r_carry <= 1'b0;
        end else begin
            if (i_incr_load) begin
                r_inc <= w_inc_clamped;
            end
            if (i_resync) begin
                r_acc   <= '0;
                r_carry <= 1'b0;
            end else if (i_en) begin
                r_acc   <= w_sum[ACC_W-1:0];
                r_carry <= w_sum[ACC_W];
            end else begin
                r_carry <= 1'b0;
            end
        end
    end

endmodule : brg_phase_acc
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Fractional baud-rate tick generator. A phase accumulator
//                produces sample ticks at OVERSAMPLE x baud. A sub-bit
//                counter decodes the mid-bit and bit-end pulses from those
//                ticks. The increment can be reloaded at run time, and the
//                phase can be restarted for start-bit alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 19200,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             resync,
    input  logic             incr_load,
    input  logic [ACC_W-1:0] incr_in,
    output logic             tick,
    output logic             mid_tick,
    output logic             bit_tick,
    output logic [ACC_W-1:0] incr_out
);

    localparam bit c_LEGAL = params_legal(OVERSAMPLE, ACC_W);

    generate
        if (c_LEGAL) begin : g_legal
            localparam longint unsigned c_INC0_FULL =
                calc_inc0(CLK_FREQ, BAUD_RATE, OVERSAMPLE, ACC_W);
            localparam logic [ACC_W-1:0] c_INC0 = c_INC0_FULL[ACC_W-1:0];
            localparam int c_SC_W = $clog2(OVERSAMPLE);
            localparam logic [c_SC_W-1:0] c_SC_MID_M1 = c_SC_W'(OVERSAMPLE / 2 - 1);
            localparam logic [c_SC_W-1:0] c_SC_LAST   = c_SC_W'(OVERSAMPLE - 1);

            logic              w_ovf;
            logic              w_carry;
            logic [ACC_W-1:0]  w_inc;
            logic [c_SC_W-1:0] r_sc;
            logic              r_mid;
            logic              r_bit;

            brg_phase_acc #(
                .ACC_W (ACC_W),
                .INC0  (c_INC0)
            ) u_phase_acc (
                .clk         (clk),
                .reset       (reset),
                .i_en        (en),
                .i_resync    (resync),
                .i_incr_load (incr_load),
                .i_incr_in   (incr_in),
                .o_ovf       (w_ovf),
                .o_carry     (w_carry),
                .o_inc       (w_inc)
            );

            // Advance the sub-bit counter on each overflow and decode the
            // mid-bit and bit-end crossings so they line up with the tick.
            always_ff @(posedge clk) begin
                if (reset || resync) begin
                    r_sc  <= '0;
                    r_mid <= 1'b0;
                    r_bit <= 1'b0;
                end else if (w_ovf) begin
                    r_sc  <= (r_sc == c_SC_LAST) ? '0 : r_sc + 1'b1;
                    r_mid <= (r_sc == c_SC_MID_M1);
                    r_bit <= (r_sc == c_SC_LAST);
                end else begin
                    r_mid <= 1'b0;
                    r_bit <= 1'b0;
                end
            end

            assign tick     = w_carry;
            assign mid_tick = r_mid;
            assign bit_tick = r_bit;
            assign incr_out = w_inc;
        end else begin : g_illegal
            // Unusable parameter set: the outputs are held inert.
            assign tick     = 1'b0;
            assign mid_tick = 1'b0;
            assign bit_tick = 1'b0;
            assign incr_out = '0;
        end
    endgenerate

endmodule : baud_tick_gen
`default_nettype wire

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19200, baud rate selected at reset.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; legal values are even and at least 4.
REQ-004 SHALL have parameter ACC_W, default 24, phase-accumulator width in bits.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port en, input, 1 bit: 1 = run, 0 = freeze.
REQ-008 SHALL have port resync, input, 1 bit: restart phase (receiver start-bit alignment).
REQ-009 SHALL have port incr_load, input, 1 bit: load a new increment.
REQ-010 SHALL have port incr_in, input, ACC_W bits: new increment value.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse at OVERSAMPLE x baud.
REQ-012 SHALL have port mid_tick, output, 1 bit: one-cycle pulse at mid-bit.
REQ-013 SHALL have port bit_tick, output, 1 bit: one-cycle pulse at bit end.
REQ-014 SHALL have port incr_out, output, ACC_W bits: currently active increment.

Function
REQ-015 SHALL compute the default increment at elaboration as INC0 = round(BAUD_RATE*OVERSAMPLE*2^ACC_W / CLK_FREQ), clamped to 2^(ACC_W-1).
REQ-016 SHALL update the accumulator on each edge with en=1 and resync=0: {carry,acc} <= acc + inc, an (ACC_W+1)-bit sum with the carry discarded after use.
REQ-017 SHALL register tick <= carry, so tick is high exactly one cycle after the edge on which the sum overflowed; tick SHALL be 0 otherwise.
REQ-018 SHALL keep a sub-counter sc in 0..OVERSAMPLE-1 that advances on every overflow and wraps to 0 after OVERSAMPLE-1.
REQ-019 SHALL assert mid_tick in the same cycle as tick when the overflow moved sc from OVERSAMPLE/2-1 to OVERSAMPLE/2.
REQ-020 SHALL assert bit_tick in the same cycle as tick when the overflow wrapped sc from OVERSAMPLE-1 to 0.
REQ-021 SHALL, when en=0, hold acc and sc and drive tick, mid_tick and bit_tick to 0.
REQ-022 SHALL, on an edge with resync=1, clear acc and sc to 0 and drive all tick outputs to 0 on the following cycle, regardless of en.
REQ-023 SHALL, on an edge with incr_load=1, latch inc <= min(incr_in, 2^(ACC_W-1)); the new value is used from the next edge onward and acc is not cleared.
REQ-024 SHALL apply both operations when incr_load and resync are asserted on the same edge.
REQ-025 SHALL produce no ticks while inc=0 and SHALL NOT treat this as an error.
REQ-026 SHALL guarantee that the clamp yields at most one tick every 2 cycles.
REQ-027 SHALL drive incr_out as the registered inc.

Reset
REQ-028 SHALL, on an edge with reset=1, set acc=0, sc=0, inc=INC0, tick=0, mid_tick=0 and bit_tick=0; reset overrides en, resync and incr_load.
REQ-029 SHALL resume accumulation from 0 on the first edge after reset deasserts, when en=1.
REQ-030 SHALL drop any tick in flight when reset is asserted mid-bit.

Structure
REQ-031 SHALL take the INC0 rounding/clamp function and OVERSAMPLE/ACC_W legality constants from shared package uart_pkg, which all UART blocks import.
REQ-032 SHALL use one sub-module, brg_phase_acc, containing the accumulator, the increment register and the carry register; sc and the tick decode remain in baud_tick_gen.

Verification
REQ-033 SHALL cover: ACC_W=8, OVERSAMPLE=16, load inc=64, en=1 -> tick every 4 clk, mid_tick at clk 32 and bit_tick at clk 64 after release, both repeating every 64 clk.
REQ-034 SHALL cover: inc=96 (ACC_W=8) -> tick intervals follow the repeating pattern 3,3,2 clk, averaging 2.667.
REQ-035 SHALL cover: resync pulsed 10 clk after a bit_tick -> next bit_tick 64 clk after resync and no tick in the cycle after resync.
REQ-036 SHALL cover: load incr_in=200 (ACC_W=8) -> incr_out=128 and tick every 2 clk.
REQ-037 SHALL cover: en=0 for 7 clk mid-bit -> no ticks while frozen and the bit period is stretched by exactly 7 clk.
REQ-038 SHALL cover: defaults (100 MHz, 19200, 16x, ACC_W=24) -> incr_out=51540 after reset and average tick period 325.52 clk, within +/-1 clk over 1000 ticks.
